// File: rtl/mips_pipe_pkg.sv
// Shared types and defaults for the MIPS pipeline hazard controller.
// HAZARD_STATS_EN enables the stall/flush statistics counters.
package mips_pipe_pkg;

    localparam int unsigned REG_W_DEF    = 5;
    localparam int unsigned WAIT_MAX_DEF = 255;
    localparam int unsigned WAIT_CNT_W   = 8;
    localparam int unsigned STAT_W       = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    function automatic logic [WAIT_CNT_W-1:0] sat_inc8(input logic [WAIT_CNT_W-1:0] v);
        return (v == {WAIT_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: the pipeline (master) supplies hazard inputs,
// the controller (slave) returns enables/flushes. Stats ports need HAZARD_STATS_EN.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_W = mips_pipe_pkg::REG_W_DEF
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] ex_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic             mem_branch_taken;
    logic             mem_wait;

    logic             pc_write;
    logic             ifid_write;
    logic             pipe_write;
    logic             idex_bubble;
    logic             flush_ifid;
    logic             flush_idex;
    logic             flush_exmem;
    logic             wait_timeout;
`ifdef HAZARD_STATS_EN
    logic [mips_pipe_pkg::STAT_W-1:0] stall_cnt;
    logic [mips_pipe_pkg::STAT_W-1:0] flush_cnt;
`endif

    modport master (
        output id_rs, id_rt, ex_rt, id_uses_rt, ex_mem_read, mem_branch_taken, mem_wait,
`ifdef HAZARD_STATS_EN
        input  stall_cnt, flush_cnt,
`endif
        input  pc_write, ifid_write, pipe_write, idex_bubble,
               flush_ifid, flush_idex, flush_exmem, wait_timeout
    );

    modport slave (
        input  id_rs, id_rt, ex_rt, id_uses_rt, ex_mem_read, mem_branch_taken, mem_wait,
`ifdef HAZARD_STATS_EN
        output stall_cnt, flush_cnt,
`endif
        output pc_write, ifid_write, pipe_write, idex_bubble,
               flush_ifid, flush_idex, flush_exmem, wait_timeout
    );

endinterface

// File: rtl/hazard_stats.sv
// Saturating counters of load-use stalls and taken-branch flushes.
// Only instantiated when HAZARD_STATS_EN is defined.
module hazard_stats
    import mips_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_evt,
    input  logic              flush_evt,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != {STAT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_evt && (flush_cnt != {STAT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch-flush / memory-wait hazard controller for a 5-stage MIPS pipe.
// Optional HAZARD_STATS_EN adds stall and flush statistics counters.
//
//   state    | meaning
//   RUN      | normal issue; load-use inserts one bubble
//   LU_STALL | bubble cycle just issued; load-use ignored for one cycle
//   MEM_WAIT | pipe frozen on mem_wait; saved_q remembers RUN or LU_STALL
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned REG_W    = REG_W_DEF,
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    hz_state_t              state_q, state_d;
    hz_state_t              saved_q, saved_d;
    hz_state_t              eff_state;
    logic                   load_use;
    logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d, wait_num;
    logic                   to_q, to_d, hit;
    logic                   pc_en, ifid_en, pipe_en, bubble, flush;

    assign load_use = hz.ex_mem_read && (hz.ex_rt != REG_W'(0)) &&
                      ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    // When the wait drops, the cycle is evaluated as if in the state we froze from.
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        state_d = RUN;
        saved_d = saved_q;
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        pipe_en = 1'b1;
        bubble  = 1'b0;
        flush   = 1'b0;
        if (hz.mem_wait) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            pipe_en = 1'b0;
            state_d = MEM_WAIT;
            saved_d = eff_state;
        end else if (hz.mem_branch_taken) begin
            flush   = 1'b1;
        end else if ((eff_state == RUN) && load_use) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            bubble  = 1'b1;
            state_d = LU_STALL;
        end
    end

    // Wait counter holds completed wait cycles; wait_num is this cycle's index.
    always_comb begin
        wait_num = (state_q == MEM_WAIT) ? sat_inc8(cnt_q) : WAIT_CNT_W'(1);
        hit      = hz.mem_wait && (32'(wait_num) >= WAIT_MAX);
        cnt_d    = hz.mem_wait ? wait_num : cnt_q;
        to_d     = to_q | hit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            saved_q <= RUN;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign hz.pc_write     = rst_n & pc_en;
    assign hz.ifid_write   = rst_n & ifid_en;
    assign hz.pipe_write   = rst_n & pipe_en;
    assign hz.idex_bubble  = rst_n & bubble;
    assign hz.flush_ifid   = ~rst_n | flush;
    assign hz.flush_idex   = ~rst_n | flush;
    assign hz.flush_exmem  = ~rst_n | flush;
    assign hz.wait_timeout = rst_n & (to_q | hit);

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_cnt, flush_cnt;

    hazard_stats u_stats (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_evt (rst_n & bubble),
        .flush_evt (rst_n & flush),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    assign hz.stall_cnt = stall_cnt;
    assign hz.flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios then random traffic,
// checked against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned WAIT_MAX = 4;

    typedef struct {
        logic [7:0] outs;  // {pc, ifid, pipe, bubble, fl_ifid, fl_idex, fl_exmem, timeout}
        int         sc;
        int         fc;
        bit         chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    bit m_post_stall = 0;
    bit m_in_wait = 0;
    int m_waits = 0;
    bit m_timeout = 0;
    int m_stalls = 0;
    int m_flushes = 0;
    bit m_cnt_known = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_W(5)) hz_if ();

    pipeline_hazard_ctrl #(.REG_W(5), .WAIT_MAX(WAIT_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz_if)
    );

    task automatic step(input bit rst, input bit mw, input bit br, input bit mr,
                        input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                        input bit urt);
        exp_t e;
        bit   lu;
        @(negedge clk);
        rst_n                  = rst;
        hz_if.mem_wait         = mw;
        hz_if.mem_branch_taken = br;
        hz_if.ex_mem_read      = mr;
        hz_if.ex_rt            = ert;
        hz_if.id_rs            = rs;
        hz_if.id_rt            = rt;
        hz_if.id_uses_rt       = urt;
        e.sc  = m_stalls;
        e.fc  = m_flushes;
        e.chk = m_cnt_known && rst;
        lu = mr && (ert != 5'd0) && ((ert == rs) || (urt && (ert == rt)));
        if (!rst) begin
            e.outs = 8'b0000_1110;
            m_post_stall = 0; m_in_wait = 0; m_waits = 0; m_timeout = 0;
            m_stalls = 0; m_flushes = 0; m_cnt_known = 1;
        end else if (mw) begin
            m_waits   = m_in_wait ? ((m_waits < 255) ? m_waits + 1 : 255) : 1;
            m_in_wait = 1;
            if (m_waits >= int'(WAIT_MAX)) m_timeout = 1;
            e.outs = {7'b000_0_000, m_timeout};
        end else begin
            m_in_wait = 0;
            if (br) begin
                e.outs = {7'b111_0_111, m_timeout};
                m_post_stall = 0;
                if (m_flushes < 65535) m_flushes++;
            end else if (lu && !m_post_stall) begin
                e.outs = {7'b001_1_000, m_timeout};
                m_post_stall = 1;
                if (m_stalls < 65535) m_stalls++;
            end else begin
                e.outs = {7'b111_0_000, m_timeout};
                m_post_stall = 0;
            end
        end
        q.push_back(e);
    endtask

    // Monitor: outputs are combinational, valid every cycle, sampled mid-low-phase.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                act = {hz_if.pc_write, hz_if.ifid_write, hz_if.pipe_write, hz_if.idex_bubble,
                       hz_if.flush_ifid, hz_if.flush_idex, hz_if.flush_exmem, hz_if.wait_timeout};
                total++;
                if (act !== e.outs) begin
                    bad++;
                    $display("FAIL outputs t=%0t actual=%b required=%b", $time, act, e.outs);
                end
`ifdef HAZARD_STATS_EN
                if (e.chk) begin
                    total++;
                    if (hz_if.stall_cnt !== 16'(e.sc) || hz_if.flush_cnt !== 16'(e.fc)) begin
                        bad++;
                        $display("FAIL stats t=%0t actual=%0d/%0d required=%0d/%0d", $time,
                                 hz_if.stall_cnt, hz_if.flush_cnt, e.sc, e.fc);
                    end
                end
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t pending=%0d required=0", $time, q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        hz_if.mem_wait = 0; hz_if.mem_branch_taken = 0; hz_if.ex_mem_read = 0;
        hz_if.ex_rt = 0; hz_if.id_rs = 0; hz_if.id_rt = 0; hz_if.id_uses_rt = 0;

        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // load-use on rs, held for the stall cycle, then idle
        step(1, 0, 0, 1, 8, 8, 0, 0);
        step(1, 0, 0, 1, 8, 8, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // load-use through rt, and rt ignored when not a source
        step(1, 0, 0, 1, 9, 3, 9, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 9, 3, 9, 0);
        // $zero exemption
        step(1, 0, 0, 1, 0, 0, 0, 1);
        // branch beats load-use
        step(1, 0, 1, 1, 8, 8, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // wait freeze during LU_STALL
        step(1, 0, 0, 1, 8, 8, 0, 0);
        repeat (3) step(1, 1, 0, 1, 8, 8, 0, 0);
        step(1, 0, 0, 1, 8, 8, 0, 0);
        step(1, 0, 0, 1, 8, 8, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // branch held across a short wait gets flushed on release
        repeat (2) step(1, 1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        // timeout at the 4th wait cycle, sticky until reset
        step(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) step(1, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // reset in the middle of a wait that followed a stall
        step(1, 0, 0, 1, 5, 5, 0, 0);
        repeat (2) step(1, 1, 0, 1, 5, 5, 0, 0);
        step(0, 1, 0, 1, 5, 5, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 5, 5, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 39) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 6) == 0, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter WAIT_MAX, default 255, the memory-wait cycle count at which timeout is flagged.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 SHALL have ports id_rs and id_rt, input, REG_W bits each, source registers of the instruction in ID.
REQ-006 SHALL have port id_uses_rt, input, 1 bit, high when the ID instruction reads rt as a source.
REQ-007 SHALL have port ex_mem_read, input, 1 bit, MemRead of the instruction in EX.
REQ-008 SHALL have port ex_rt, input, REG_W bits, destination rt of the load in EX.
REQ-009 SHALL have port mem_branch_taken, input, 1 bit, branch resolved taken in MEM.
REQ-010 SHALL have port mem_wait, input, 1 bit, data memory not ready.
REQ-011 SHALL have ports pc_write and ifid_write, output, 1 bit each, PC and IF/ID load enables.
REQ-012 SHALL have port pipe_write, output, 1 bit, ID/EX, EX/MEM and MEM/WB load enable.
REQ-013 SHALL have port idex_bubble, output, 1 bit, which zeroes the WB, M and EX control fields entering ID/EX.
REQ-014 SHALL have ports flush_ifid, flush_idex and flush_exmem, output, 1 bit each.
REQ-015 SHALL have port wait_timeout, output, 1 bit, sticky timeout flag.

Function
REQ-016 SHALL implement FSM states RUN, LU_STALL and MEM_WAIT.
REQ-017 SHALL define load-use as ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
REQ-018 SHALL, in RUN with load-use and no higher-priority event, drive pc_write=0, ifid_write=0, idex_bubble=1 and pipe_write=1 in the same cycle (zero latency), then go to LU_STALL.
REQ-019 SHALL, in LU_STALL, ignore load-use, drive normal enables, and return to RUN after exactly one cycle.
REQ-020 SHALL, on mem_branch_taken with mem_wait low, drive flush_ifid, flush_idex and flush_exmem to 1 that cycle, keep all enables 1, suppress any load-use stall, and go to RUN.
REQ-021 SHALL, while mem_wait is high in any state, drive pc_write=0, ifid_write=0 and pipe_write=0, drive no flush and no bubble, enter MEM_WAIT, and save the prior state (RUN or LU_STALL).
REQ-022 SHALL apply the priority order mem_wait > mem_branch_taken > load-use.
REQ-023 SHALL, when mem_wait falls, evaluate the current inputs in the saved state that cycle (a held branch is then flushed).
REQ-024 SHALL keep an 8-bit wait counter, cleared on MEM_WAIT entry, incrementing per wait cycle and saturating at 255.
REQ-025 SHALL set wait_timeout on the cycle the counter reaches WAIT_MAX and hold it until reset.
REQ-026 SHALL, with no event, drive all enables 1 and all flushes and bubble 0.

Reset
REQ-027 SHALL, while rst_n=0, force the state to RUN, the counter to 0, wait_timeout=0, pc_write=ifid_write=pipe_write=0, all flushes=1 and idex_bubble=0.
REQ-028 SHALL, when reset is asserted mid-stall or mid-wait, abandon the saved state and resume in RUN on the first cycle after release.

Configuration
REQ-029 SHALL, with HAZARD_STATS_EN defined, add outputs stall_cnt[15:0] and flush_cnt[15:0], counting load-use stalls and taken-branch flushes, saturating at 16'hFFFF, and reset to 0.
REQ-030 SHALL, without HAZARD_STATS_EN, omit those ports and their logic entirely.

Structure
REQ-031 SHALL place the state enum, the REG_W default and the WAIT_MAX default in shared package mips_pipe_pkg.
REQ-032 SHALL implement the counters of REQ-029 in sub-module hazard_stats, instantiated only under HAZARD_STATS_EN.

Verification
REQ-033 SHALL cover load-use: ex_mem_read=1, ex_rt=8, id_rs=8 -> pc_write=0, ifid_write=0, idex_bubble=1 for one cycle, then all enables 1.
REQ-034 SHALL cover the $zero exemption: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall.
REQ-035 SHALL cover branch priority: load-use and mem_branch_taken=1 in the same cycle -> three flushes, pc_write=1, no bubble.
REQ-036 SHALL cover a wait freeze: mem_wait high for 3 cycles during LU_STALL -> all enables 0 for 3 cycles, then one LU_STALL cycle, then RUN.
REQ-037 SHALL cover timeout: WAIT_MAX=4 with mem_wait held for 6 cycles -> wait_timeout rises on the 4th wait cycle and stays 1 until rst_n=0.
REQ-038 SHALL cover reset mid-wait: rst_n=0 for 1 cycle during MEM_WAIT -> flushes 1, wait_timeout 0, and RUN with normal enables after release.
